// File: rtl/dm_pipe.sv
// Data memory with one-cycle registered response, W/H/B load/store lanes and a zero sweep after reset.
// Optional store trace is enabled by defining DM_PIPE_TRACE_EN.
module dm_pipe #(
    parameter int ADDR_WIDTH     = 14,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_invalid,
    output logic        busy
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [2:0] M_NONE = 3'd0;
    localparam logic [2:0] M_W    = 3'd1;
    localparam logic [2:0] M_H    = 3'd2;
    localparam logic [2:0] M_HU   = 3'd3;
    localparam logic [2:0] M_B    = 3'd4;
    localparam logic [2:0] M_BU   = 3'd5;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;
    localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_invalid_q, rsp_invalid_d;
    logic [31:0]       mem_q [DEPTH];

    logic              accept;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rd_word;
    logic [15:0]       lane_h;
    logic [7:0]        lane_b;
    logic              invalid;
    logic [31:0]       load_data;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    logic              unused_ok;
    assign unused_ok = ^{req_pc, req_addr[31:ADDR_WIDTH]};

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // FSM: next state; RUN is terminal until reset
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_IDX) state_d = ST_RUN;
        end
    end

    // FSM: outputs; rst_n gating keeps req_ready low in reset even when no sweep is configured
    always_comb begin
        busy      = (state_q == ST_CLEAR);
        req_ready = rst_n && (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
    end

    assign accept = req_valid && req_ready;

    always_comb begin
        idx     = req_addr[ADDR_WIDTH-1:2];
        rd_word = mem_q[idx];
        lane_h  = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (req_addr[1:0])
            2'd0:    lane_b = rd_word[7:0];
            2'd1:    lane_b = rd_word[15:8];
            2'd2:    lane_b = rd_word[23:16];
            default: lane_b = rd_word[31:24];
        endcase

        case (req_mode)
            M_NONE, M_B, M_BU: invalid = 1'b0;
            M_W:               invalid = (req_addr[1:0] != 2'b00);
            M_H, M_HU:         invalid = req_addr[0];
            default:           invalid = 1'b1;
        endcase

        load_data = '0;
        if (!req_we && !invalid) begin
            case (req_mode)
                M_W:     load_data = rd_word;
                M_H:     load_data = {{16{lane_h[15]}}, lane_h};
                M_HU:    load_data = {16'h0000, lane_h};
                M_B:     load_data = {{24{lane_b[7]}}, lane_b};
                M_BU:    load_data = {24'h000000, lane_b};
                default: load_data = '0;
            endcase
        end

        // Store data is replicated across lanes so the byte enables alone pick the target
        wr_be   = 4'b0000;
        wr_data = '0;
        if (req_we && !invalid) begin
            case (req_mode)
                M_W: begin
                    wr_be   = 4'b1111;
                    wr_data = req_wdata;
                end
                M_H: begin
                    wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{req_wdata[15:0]}};
                end
                M_B: begin
                    wr_be   = 4'b0001 << req_addr[1:0];
                    wr_data = {4{req_wdata[7:0]}};
                end
                default: begin
                    wr_be   = 4'b0000;
                    wr_data = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (accept) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // A new acceptance overwrites the held response even while it is being consumed
    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_invalid_d = rsp_invalid_q;
        if (accept) begin
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = load_data;
            rsp_invalid_d = invalid;
        end else if (rsp_ready) begin
            rsp_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_invalid_q <= 1'b0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_invalid_q <= rsp_invalid_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_invalid = rsp_invalid_q;

`ifdef DM_PIPE_TRACE_EN
    always_ff @(posedge clk) begin
        if (accept && req_we && !invalid)
            $display("DM %0t pc=%08h addr=%08h data=%08h",
                     $time, req_pc, {req_addr[31:2], 2'b00}, req_wdata);
    end
`else
`endif

endmodule

// File: tb/tb_dm_pipe.sv
// Directed bench for dm_pipe with a 16-word memory: sweep timing, lane decode,
// illegal requests, wrap-around, back-pressure and asynchronous reset.
module tb_dm_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_invalid;
    logic        busy;

    int passed = 0;
    int total  = 0;

    localparam logic [2:0] M_NONE = 3'd0;
    localparam logic [2:0] M_W    = 3'd1;
    localparam logic [2:0] M_H    = 3'd2;
    localparam logic [2:0] M_HU   = 3'd3;
    localparam logic [2:0] M_B    = 3'd4;
    localparam logic [2:0] M_BU   = 3'd5;

    dm_pipe #(.ADDR_WIDTH(6), .CLEAR_ON_RESET(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_mode    (req_mode),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_pc      (req_pc),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_invalid (rsp_invalid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] rdata, input logic inv);
        chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, rdata);
        chk({tag, "_inv"}, {31'b0, rsp_invalid}, {31'b0, inv});
    endtask

    // Presents one request, lets it be accepted on the next rising edge, returns #1 after it
    task automatic xfer(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wdata);
        req_we    = we;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = 32'h0000_1000 + addr;
        req_valid = 1'b1;
        #1;
        chk("ready_at_issue", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Called on the falling edge where rst_n is released; counts busy cycles
    task automatic count_sweep(input string tag);
        int cnt = 0;
        logic ready_seen = 1'b0;
        for (int i = 0; i < 100 && busy; i++) begin
            if (req_ready) ready_seen = 1'b1;
            cnt++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, cnt, 32'd16);
        chk({tag, "_ready_in_clear"}, {31'b0, ready_seen}, 32'd0);
        chk({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        chk({tag, "_ready_after"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_mode  = M_NONE;
        req_addr  = '0;
        req_wdata = '0;
        req_pc    = '0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_inv", {31'b0, rsp_invalid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b1;
        count_sweep("sweep1");

        xfer(1'b0, M_W, 32'h3C, 32'h0);            chk_rsp("swept_w15", 32'h0, 1'b0);

        xfer(1'b1, M_W, 32'h8, 32'h1234_5678);     chk_rsp("st_w_8", 32'h0, 1'b0);
        xfer(1'b0, M_B, 32'hB, 32'h0);             chk_rsp("ld_b_b", 32'h0000_0012, 1'b0);
        xfer(1'b0, M_BU, 32'hA, 32'h0);            chk_rsp("ld_bu_a", 32'h0000_0034, 1'b0);
        xfer(1'b0, M_H, 32'hA, 32'h0);             chk_rsp("ld_h_a", 32'h0000_1234, 1'b0);
        xfer(1'b0, M_H, 32'h8, 32'h0);             chk_rsp("ld_h_8", 32'h0000_5678, 1'b0);

        xfer(1'b1, M_H, 32'hE, 32'hFFFF_8001);     chk_rsp("st_h_e", 32'h0, 1'b0);
        xfer(1'b0, M_H, 32'hE, 32'h0);             chk_rsp("ld_h_e", 32'hFFFF_8001, 1'b0);
        xfer(1'b0, M_HU, 32'hE, 32'h0);            chk_rsp("ld_hu_e", 32'h0000_8001, 1'b0);
        xfer(1'b0, M_W, 32'hC, 32'h0);             chk_rsp("ld_w_c", 32'h8001_0000, 1'b0);

        xfer(1'b1, M_B, 32'h5, 32'h0000_00FF);     chk_rsp("st_b_5", 32'h0, 1'b0);
        xfer(1'b0, M_W, 32'h4, 32'h0);             chk_rsp("ld_w_4", 32'h0000_FF00, 1'b0);
        xfer(1'b0, M_B, 32'h5, 32'h0);             chk_rsp("ld_b_5", 32'hFFFF_FFFF, 1'b0);
        xfer(1'b0, M_BU, 32'h5, 32'h0);            chk_rsp("ld_bu_5", 32'h0000_00FF, 1'b0);

        xfer(1'b0, M_W, 32'h2, 32'h0);             chk_rsp("ill_ld_w_2", 32'h0, 1'b1);
        xfer(1'b1, M_H, 32'h3, 32'h0000_BEEF);     chk_rsp("ill_st_h_3", 32'h0, 1'b1);
        xfer(1'b0, 3'd7, 32'h4, 32'h0);            chk_rsp("ill_mode7", 32'h0, 1'b1);
        xfer(1'b1, 3'd6, 32'h4, 32'hDEAD_BEEF);    chk_rsp("ill_mode6", 32'h0, 1'b1);
        xfer(1'b1, M_W, 32'h6, 32'hDEAD_BEEF);     chk_rsp("ill_st_w_6", 32'h0, 1'b1);
        xfer(1'b0, M_W, 32'h0, 32'h0);             chk_rsp("ill_keep_w0", 32'h0, 1'b0);
        xfer(1'b0, M_W, 32'h4, 32'h0);             chk_rsp("ill_keep_w1", 32'h0000_FF00, 1'b0);

        xfer(1'b1, M_W, 32'h1000_0010, 32'hCAFE_F00D); chk_rsp("wrap_st", 32'h0, 1'b0);
        xfer(1'b0, M_W, 32'h10, 32'h0);            chk_rsp("wrap_ld", 32'hCAFE_F00D, 1'b0);
        xfer(1'b1, M_NONE, 32'h10, 32'h0);         chk_rsp("st_none", 32'h0, 1'b0);
        xfer(1'b1, M_BU, 32'h10, 32'h0);           chk_rsp("st_bu", 32'h0, 1'b0);
        xfer(1'b1, M_HU, 32'h10, 32'h0);           chk_rsp("st_hu", 32'h0, 1'b0);
        xfer(1'b0, M_NONE, 32'h10, 32'h0);         chk_rsp("ld_none", 32'h0, 1'b0);
        xfer(1'b0, M_W, 32'h50, 32'h0);            chk_rsp("wrap_ld2", 32'hCAFE_F00D, 1'b0);

        xfer(1'b1, M_W, 32'h14, 32'hA5A5_A5A5);    chk_rsp("b2b_st", 32'h0, 1'b0);
        xfer(1'b0, M_W, 32'h14, 32'h0);            chk_rsp("b2b_ld", 32'hA5A5_A5A5, 1'b0);
        @(posedge clk);
        #1;
        chk("rsp_drained", {31'b0, rsp_valid}, 32'd0);

        rsp_ready = 1'b0;
        xfer(1'b0, M_W, 32'h8, 32'h0);             chk_rsp("bp_first", 32'h1234_5678, 1'b0);
        req_we    = 1'b0;
        req_mode  = M_W;
        req_addr  = 32'h10;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk_rsp("bp_hold", 32'h1234_5678, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk_rsp("bp_next", 32'hCAFE_F00D, 1'b0);
        @(posedge clk);
        #1;
        chk("bp_drained", {31'b0, rsp_valid}, 32'd0);

        rsp_ready = 1'b0;
        xfer(1'b0, M_W, 32'h8, 32'h0);             chk_rsp("pre_rst", 32'h1234_5678, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("async_rst_rdata", rsp_rdata, 32'd0);
        chk("async_rst_busy", {31'b0, busy}, 32'd1);
        chk("async_rst_ready", {31'b0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_sweep_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_sweep_rst_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_sweep("sweep2");

        xfer(1'b0, M_W, 32'h8, 32'h0);             chk_rsp("post_rst_w2", 32'h0, 1'b0);
        xfer(1'b0, M_W, 32'h10, 32'h0);            chk_rsp("post_rst_w4", 32'h0, 1'b0);
        xfer(1'b0, M_W, 32'h3C, 32'h0);            chk_rsp("post_rst_w15", 32'h0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
